// File: rtl/watch_pkg.sv
// Shared types and decode helpers for the stopwatch/timer run-control sequencer.
package watch_pkg;

  typedef enum logic [2:0] {
    SW_IDLE  = 3'd0,
    SW_RUN   = 3'd1,
    SW_LAP   = 3'd2,
    SW_PAUSE = 3'd3,
    TM_IDLE  = 3'd4,
    TM_RUN   = 3'd5,
    TM_PAUSE = 3'd6,
    TM_ALARM = 3'd7
  } watch_state_t;

  localparam logic [1:0] DISP_SW  = 2'b00;
  localparam logic [1:0] DISP_TM  = 2'b01;
  localparam logic [1:0] DISP_LAP = 2'b10;

  function automatic logic [1:0] disp_of(input watch_state_t s);
    if (s == SW_LAP)  return DISP_LAP;
    if (s >= TM_IDLE) return DISP_TM;
    return DISP_SW;
  endfunction

endpackage

// File: rtl/watch_ctrl_btn_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one raw button.
module btn_edge (
  input  logic clk,
  input  logic nrst,
  input  logic async_in,
  output logic pos_edge
);

  // [0],[1] synchronize, [2] holds the previous synchronized level.
  // Reset to "pressed" so a button held through reset release never looks like a new press.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q   <= 3'b111;
      pos_edge <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], async_in};
      pos_edge <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// Mode/run-control sequencer: buttons in, counter/timer enables, clears, loads,
// display select and blinking alarm out. All outputs are registered.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int ALARM_TICKS = 50
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         pb_mode,
  input  logic         pb_start,
  input  logic         pb_lap,
  input  logic         pb_clear,
  input  logic         tick,
  input  logic         time_up,
  output logic         sw_en,
  output logic         sw_clr,
  output logic         tm_en,
  output logic         tm_clr,
  output logic         tm_load,
  output logic [1:0]   disp_sel,
  output logic         alarm,
  output watch_state_t state_dbg
);

  localparam int CW = $clog2(ALARM_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(ALARM_TICKS - 1);

  logic p_mode, p_start, p_lap, p_clear;

  btn_edge u_mode  (.clk(clk), .nrst(nrst), .async_in(pb_mode),  .pos_edge(p_mode));
  btn_edge u_start (.clk(clk), .nrst(nrst), .async_in(pb_start), .pos_edge(p_start));
  btn_edge u_lap   (.clk(clk), .nrst(nrst), .async_in(pb_lap),   .pos_edge(p_lap));
  btn_edge u_clear (.clk(clk), .nrst(nrst), .async_in(pb_clear), .pos_edge(p_clear));

  // Only the highest-priority press survives; the rest are dropped.
  logic w_clear, w_mode, w_start, w_lap, w_any;
  assign w_clear = p_clear;
  assign w_mode  = p_mode  & ~p_clear;
  assign w_start = p_start & ~p_mode & ~p_clear;
  assign w_lap   = p_lap   & ~p_start & ~p_mode & ~p_clear;
  assign w_any   = p_clear | p_mode | p_start | p_lap;

  watch_state_t state, nxt;
  logic         clr_sw, clr_tm, load_tm;
  logic [CW-1:0] blink_cnt;

  always_comb begin
    nxt     = state;
    clr_sw  = 1'b0;
    clr_tm  = 1'b0;
    load_tm = 1'b0;
    case (state)
      SW_IDLE: begin
        if (w_clear)      clr_sw = 1'b1;
        else if (w_mode)  nxt = TM_IDLE;
        else if (w_start) nxt = SW_RUN;
      end
      SW_RUN: begin
        if (w_clear)      begin nxt = SW_IDLE; clr_sw = 1'b1; end
        else if (w_start) nxt = SW_PAUSE;
        else if (w_lap)   nxt = SW_LAP;
      end
      SW_LAP: begin
        if (w_clear)      begin nxt = SW_IDLE; clr_sw = 1'b1; end
        else if (w_start) nxt = SW_PAUSE;
        else if (w_lap)   nxt = SW_RUN;
      end
      SW_PAUSE: begin
        if (w_clear)      begin nxt = SW_IDLE; clr_sw = 1'b1; end
        else if (w_mode)  nxt = TM_IDLE;
        else if (w_start) nxt = SW_RUN;
      end
      TM_IDLE: begin
        if (w_clear)      clr_tm = 1'b1;
        else if (w_mode)  nxt = SW_IDLE;
        else if (w_start) begin
          if (!time_up) nxt = TM_RUN;
        end
        else if (w_lap)   load_tm = 1'b1;
      end
      TM_RUN: begin
        // Expiry outranks every button except clear.
        if (w_clear)      begin nxt = TM_IDLE; clr_tm = 1'b1; end
        else if (time_up) nxt = TM_ALARM;
        else if (w_start) nxt = TM_PAUSE;
      end
      TM_PAUSE: begin
        if (w_clear)      begin nxt = TM_IDLE; clr_tm = 1'b1; end
        else if (w_mode)  nxt = SW_IDLE;
        else if (w_start) nxt = TM_RUN;
      end
      TM_ALARM: begin
        if (w_any) begin nxt = TM_IDLE; clr_tm = 1'b1; end
      end
      default: nxt = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= SW_IDLE;
      sw_en     <= 1'b0;
      sw_clr    <= 1'b0;
      tm_en     <= 1'b0;
      tm_clr    <= 1'b0;
      tm_load   <= 1'b0;
      disp_sel  <= DISP_SW;
      alarm     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      state    <= nxt;
      sw_clr   <= clr_sw;
      tm_clr   <= clr_tm;
      tm_load  <= load_tm;
      sw_en    <= (nxt == SW_RUN) || (nxt == SW_LAP);
      tm_en    <= (nxt == TM_RUN);
      disp_sel <= disp_of(nxt);
      if (nxt != TM_ALARM) begin
        alarm     <= 1'b0;
        blink_cnt <= '0;
      end else if (state != TM_ALARM) begin
        alarm     <= 1'b1;
        blink_cnt <= '0;
      end else if (tick) begin
        if (blink_cnt == LAST) begin
          alarm     <= ~alarm;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + CW'(1);
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_watch_ctrl.sv
// Scoreboard bench for watch_ctrl: a flag-based reference model pushes the expected
// output word each clock; a monitor pops and compares on the falling edge.
module tb_watch_ctrl;
  import watch_pkg::*;

  localparam int AT = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic pb_mode = 1'b0, pb_start = 1'b0, pb_lap = 1'b0, pb_clear = 1'b0;
  logic tick = 1'b0, time_up = 1'b0;
  logic sw_en, sw_clr, tm_en, tm_clr, tm_load, alarm;
  logic [1:0] disp_sel;
  watch_state_t state_dbg;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  watch_ctrl #(.ALARM_TICKS(AT)) dut (
    .clk(clk), .nrst(nrst),
    .pb_mode(pb_mode), .pb_start(pb_start), .pb_lap(pb_lap), .pb_clear(pb_clear),
    .tick(tick), .time_up(time_up),
    .sw_en(sw_en), .sw_clr(sw_clr), .tm_en(tm_en), .tm_clr(tm_clr), .tm_load(tm_load),
    .disp_sel(disp_sel), .alarm(alarm), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  bit tm_mode, running, paused, lap_view, alarming, blink;
  int cnt;
  bit [3:0] h1, h2, h3, h4, pr;
  bit e_swclr, e_tmclr, e_load;

  function automatic logic [2:0] exp_state();
    if (alarming) return TM_ALARM;
    if (tm_mode)  return running ? TM_RUN : (paused ? TM_PAUSE : TM_IDLE);
    if (running)  return lap_view ? SW_LAP : SW_RUN;
    return paused ? SW_PAUSE : SW_IDLE;
  endfunction

  function automatic logic [10:0] exp_word();
    logic [1:0] d;
    d = (alarming || tm_mode) ? 2'b01 : ((running && lap_view) ? 2'b10 : 2'b00);
    return {exp_state(), !tm_mode && running, e_swclr, tm_mode && running,
            e_tmclr, e_load, d, alarming && blink};
  endfunction

  task automatic model_reset();
    tm_mode = 0; running = 0; paused = 0; lap_view = 0; alarming = 0; blink = 0; cnt = 0;
    e_swclr = 0; e_tmclr = 0; e_load = 0;
    h1 = '1; h2 = '1; h3 = '1; h4 = '1;
  endtask

  // p = {clear, mode, start, lap} presses seen by the sequencer this edge
  task automatic model_step(input bit [3:0] p);
    bit c, m, s, l;
    c = p[3];
    m = p[2] && !c;
    s = p[1] && !c && !p[2];
    l = p[0] && !c && !p[2] && !p[1];
    e_swclr = 0; e_tmclr = 0; e_load = 0;
    if (alarming) begin
      if (p != 4'b0) begin
        alarming = 0; blink = 0; e_tmclr = 1;
      end else if (tick) begin
        cnt++;
        if (cnt == AT) begin blink = !blink; cnt = 0; end
      end
    end else if (!tm_mode) begin
      if (c) begin e_swclr = 1; running = 0; paused = 0; lap_view = 0; end
      else if (m) begin if (!running) begin tm_mode = 1; paused = 0; end end
      else if (s) begin
        if (running) begin running = 0; paused = 1; lap_view = 0; end
        else begin running = 1; paused = 0; end
      end
      else if (l) begin if (running) lap_view = !lap_view; end
    end else begin
      if (c) begin e_tmclr = 1; running = 0; paused = 0; end
      else if (running && time_up) begin alarming = 1; running = 0; blink = 1; cnt = 0; end
      else if (m) begin if (!running) begin tm_mode = 0; paused = 0; end end
      else if (s) begin
        if (running) begin running = 0; paused = 1; end
        else if (paused) begin running = 1; paused = 0; end
        else if (!time_up) running = 1;
      end
      else if (l) begin if (!running && !paused) e_load = 1; end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back('0);
      end else begin
        // A raw press reaches the sequencer three edges after it is first sampled.
        pr = h3 & ~h4;
        h4 = h3; h3 = h2; h2 = h1;
        h1 = {pb_clear, pb_mode, pb_start, pb_lap};
        model_step(pr);
        exp_q.push_back(exp_word());
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s t=%0t got=%b exp=%b (state,sw_en,sw_clr,tm_en,tm_clr,tm_load,disp,alarm)",
               name, $time, got, exp);
    end
  endtask

  function automatic logic [10:0] dut_word();
    return {state_dbg, sw_en, sw_clr, tm_en, tm_clr, tm_load, disp_sel, alarm};
  endfunction

  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_word(), e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  localparam bit [3:0] B_CLR = 4'b1000, B_MODE = 4'b0100, B_START = 4'b0010, B_LAP = 4'b0001;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit [3:0] mask);
    @(negedge clk);
    {pb_clear, pb_mode, pb_start, pb_lap} = mask;
    @(negedge clk);
    {pb_clear, pb_mode, pb_start, pb_lap} = 4'b0;
    idle(5);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 check("reset_async", dut_word(), 11'b0);
  endtask

  initial begin
    #1_000_000;
    fails++;
    checks++;
    $display("FAIL timeout: bench did not finish by %0t", $time);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    idle(3);
    nrst = 1'b1;
    idle(3);

    // stopwatch run / lap / lap / pause / clear
    press(B_START); press(B_LAP); press(B_LAP); press(B_START); press(B_CLR);

    // reset mid-run, start held through release
    press(B_START);
    async_reset_check();
    @(negedge clk); pb_start = 1'b1;
    idle(3);
    nrst = 1'b1;
    idle(6);
    pb_start = 1'b0;
    idle(6);

    // simultaneous presses
    press(B_START); press(B_CLR | B_START);
    press(B_START); press(B_START); press(B_MODE | B_START);

    // timer preset, run, expiry, blink, dismiss with lap
    press(B_LAP); press(B_START);
    @(negedge clk); time_up = 1'b1;
    idle(2);
    ticks(7);
    press(B_LAP);

    // start blocked while expired, then back to stopwatch; mode ignored while running
    press(B_START);
    time_up = 1'b0;
    press(B_MODE); press(B_START); press(B_MODE); press(B_START); press(B_CLR);
    press(B_MODE);

    // clear and time_up at the same edge in TM_RUN
    press(B_START);
    @(negedge clk); pb_clear = 1'b1;
    @(negedge clk); pb_clear = 1'b0;
    @(negedge clk);
    @(negedge clk); time_up = 1'b1;
    idle(3);
    time_up = 1'b0;
    idle(4);

    // randomized buttons, tick and time_up
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) time_up = ~time_up;
      if ($urandom_range(0, 15) == 0) pb_clear = ~pb_clear;
      if ($urandom_range(0, 9)  == 0) pb_mode  = ~pb_mode;
      if ($urandom_range(0, 7)  == 0) pb_start = ~pb_start;
      if ($urandom_range(0, 7)  == 0) pb_lap   = ~pb_lap;
      if (i == 1500) begin
        async_reset_check();
        idle(2);
        nrst = 1'b1;
      end
    end
    {pb_clear, pb_mode, pb_start, pb_lap} = 4'b0;
    tick = 1'b0;
    time_up = 1'b0;
    idle(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
